// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch (I) and load/store (D) requesters
//
// One transaction in flight at a time. In IDLE the winning requester is granted
// and its command is forwarded to memory in the same cycle. In WAIT the
// memory's completion is routed back to the owner in the same cycle. If the
// memory stays silent for TIMEOUT WAIT cycles, the owner gets a zero-data
// response and a sticky error flag shuts the arbiter down until reset.
//
// Ports:
//   CLK, RSTN                  clock, asynchronous active-low reset
//   i_req/i_addr               fetch request in
//   i_gnt/i_rvalid/i_rdata     fetch grant and response out
//   d_req/d_we/d_addr/d_wdata/d_be  load/store request in
//   d_gnt/d_rvalid/d_rdata     load/store grant and response out
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  memory command out
//   mem_rvalid/mem_rdata       memory completion in
//   err                        sticky timeout flag out
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit RR_EN   = 1'b0,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, next_state;
  logic            owner;       // 0 = I, 1 = D
  logic            last_owner;
  logic            owner_store; // in-flight D transaction is a store
  logic [TO_W-1:0] cnt;
  logic            err_q;

  logic            winner;
  logic            grant_en;
  logic            resp_ok;
  logic            resp_to;

  // D wins contention under fixed priority; under round-robin the side that
  // did not own the previous transaction wins.
  always_comb begin
    winner = 1'b0;
    if (i_req && d_req) begin
      winner = RR_EN ? ~last_owner : 1'b1;
    end else begin
      winner = d_req;
    end
  end

  // RSTN gates every combinational path so outputs read zero during reset.
  assign grant_en = RSTN && (state == IDLE) && !err_q && (i_req || d_req);
  assign resp_ok  = RSTN && (state == WAIT) && mem_rvalid;
  assign resp_to  = RSTN && (state == WAIT) && !mem_rvalid && (cnt == CNT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_en) next_state = WAIT;
      WAIT:    if (resp_ok || resp_to) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b0;
      owner_store <= 1'b0;
      cnt         <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_en) begin
        owner       <= winner;
        last_owner  <= winner;
        owner_store <= winner && d_we;
        cnt         <= '0;
      end else if (state == WAIT && !mem_rvalid) begin
        cnt <= cnt + 1'b1;
      end
      if (resp_to) err_q <= 1'b1;
    end
  end

  always_comb begin
    i_gnt     = grant_en && !winner;
    d_gnt     = grant_en && winner;
    mem_req   = grant_en;
    mem_we    = grant_en && winner && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_en) begin
      mem_addr = winner ? d_addr : i_addr;
      mem_be   = (winner && d_we) ? d_be : '1;
      if (winner) mem_wdata = d_wdata;
    end

    i_rvalid = (resp_ok || resp_to) && !owner;
    d_rvalid = (resp_ok || resp_to) && owner;
    i_rdata  = (resp_ok && !owner) ? mem_rdata : '0;
    d_rdata  = (resp_ok && owner && !owner_store) ? mem_rdata : '0;

    // Raised in the timeout cycle itself so the requester sees the error with
    // its zero-data response.
    err = RSTN && (err_q || resp_to);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter, fixed-priority and round-robin instances
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        i_req, d_req, d_we, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic        f_i_gnt, f_i_rvalid, f_d_gnt, f_d_rvalid, f_mem_req, f_mem_we, f_err;
  logic [31:0] f_i_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
  logic [3:0]  f_mem_be;
  logic        r_i_gnt, r_i_rvalid, r_d_gnt, r_d_rvalid, r_mem_req, r_mem_we, r_err;
  logic [31:0] r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0), .TIMEOUT(4), .TO_W(8)) u_fp (
    .CLK(CLK), .RSTN(RSTN),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(f_i_gnt), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_be(f_mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(f_err)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1), .TIMEOUT(4), .TO_W(8)) u_rr (
    .CLK(CLK), .RSTN(RSTN),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(r_i_gnt), .i_rvalid(r_i_rvalid), .i_rdata(r_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(r_d_gnt), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
    .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_be(r_mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(r_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks run mid-cycle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    RSTN = 0;
    step();
    step();
    RSTN = 1;
  endtask

  initial begin
    idle_inputs();
    RSTN = 0;
    #1;
    // Reset: outputs forced low even with requests active.
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h55; d_be = 4'h1;
    mem_rvalid = 1; mem_rdata = 32'h1234;
    settle();
    chk("rst_mem_req", {31'b0, f_mem_req | r_mem_req}, 32'd0);
    chk("rst_gnt", {30'b0, f_i_gnt | r_i_gnt, f_d_gnt | r_d_gnt}, 32'd0);
    chk("rst_mem_addr", f_mem_addr | r_mem_addr, 32'd0);
    chk("rst_mem_buses", {f_mem_be, r_mem_be, 22'b0, f_mem_we, r_mem_we} | f_mem_wdata, 32'd0);
    chk("rst_rvalid", {28'b0, f_i_rvalid, f_d_rvalid, r_i_rvalid, r_d_rvalid}, 32'd0);
    chk("rst_err", {30'b0, f_err, r_err}, 32'd0);
    step();
    idle_inputs();
    RSTN = 1;
    step();

    // Fetch only, memory answers 3 cycles after the command.
    i_req = 1; i_addr = 32'h10;
    settle();
    chk("fetch_gnt", {30'b0, f_i_gnt, r_i_gnt}, 32'd3);
    chk("fetch_mem_req", {30'b0, f_mem_req, r_mem_req}, 32'd3);
    chk("fetch_mem_addr", f_mem_addr, 32'h10);
    chk("fetch_mem_be", {28'b0, f_mem_be}, 32'hF);
    chk("fetch_mem_we", {31'b0, f_mem_we}, 32'd0);
    step();
    i_req = 0;
    for (int c = 1; c <= 2; c++) begin
      settle();
      chk("fetch_wait_rvalid", {30'b0, f_i_rvalid, f_d_rvalid}, 32'd0);
      chk("fetch_wait_gnt", {31'b0, f_mem_req}, 32'd0);
      step();
    end
    mem_rvalid = 1; mem_rdata = 32'h0340_00EF;
    settle();
    chk("fetch_i_rvalid", {30'b0, f_i_rvalid, r_i_rvalid}, 32'd3);
    chk("fetch_i_rdata", f_i_rdata, 32'h0340_00EF);
    chk("fetch_d_rvalid", {30'b0, f_d_rvalid, r_d_rvalid}, 32'd0);
    step();
    idle_inputs();
    settle();
    chk("fetch_after_idle", {30'b0, f_i_rvalid, f_mem_req}, 32'd0);
    step();

    // Store.
    d_req = 1; d_we = 1; d_addr = 32'h1FC; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    settle();
    chk("store_d_gnt", {30'b0, f_d_gnt, f_i_gnt}, 32'd2);
    chk("store_mem_we", {31'b0, f_mem_we}, 32'd1);
    chk("store_mem_addr", f_mem_addr, 32'h1FC);
    chk("store_mem_wdata", f_mem_wdata, 32'hDEAD_BEEF);
    chk("store_mem_be", {28'b0, f_mem_be}, 32'h3);
    step();
    idle_inputs();
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    settle();
    chk("store_d_rvalid", {30'b0, f_d_rvalid, f_i_rvalid}, 32'd2);
    chk("store_d_rdata", f_d_rdata, 32'd0);
    step();
    idle_inputs();

    // Contention, both requesting continuously, memory latency 1.
    do_reset();
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      mem_rvalid = 0;
      settle();
      chk("fp_cont_gnt", {30'b0, f_i_gnt, f_d_gnt}, 32'd1);
      chk("rr_cont_gnt", {30'b0, r_i_gnt, r_d_gnt}, {30'b0, ~exp_d, exp_d});
      chk("rr_cont_addr", r_mem_addr, exp_d ? 32'h200 : 32'h100);
      chk("fp_cont_be", {28'b0, f_mem_be}, 32'hF);
      step();
      mem_rvalid = 1; mem_rdata = 32'hA000_0000 + k;
      settle();
      chk("cont_wait_gnt", {28'b0, f_i_gnt, f_d_gnt, r_i_gnt, r_d_gnt}, 32'd0);
      chk("fp_cont_rvalid", {30'b0, f_i_rvalid, f_d_rvalid}, 32'd1);
      chk("fp_cont_rdata", f_d_rdata, 32'hA000_0000 + k);
      chk("rr_cont_rvalid", {30'b0, r_i_rvalid, r_d_rvalid}, {30'b0, ~exp_d, exp_d});
      chk("rr_cont_rdata", exp_d ? r_d_rdata : r_i_rdata, 32'hA000_0000 + k);
      chk("rr_cont_other_rdata", exp_d ? r_i_rdata : r_d_rdata, 32'd0);
      step();
    end
    idle_inputs();

    // Timeout with TIMEOUT = 4: memory never answers a fetch.
    do_reset();
    i_req = 1; i_addr = 32'h44;
    settle();
    chk("to_gnt", {31'b0, f_i_gnt}, 32'd1);
    step();
    i_req = 0; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk("to_wait_quiet", {29'b0, f_i_rvalid, f_d_rvalid, f_err}, 32'd0);
      step();
    end
    settle();
    chk("to_i_rvalid", {30'b0, f_i_rvalid, r_i_rvalid}, 32'd3);
    chk("to_i_rdata", f_i_rdata, 32'd0);
    chk("to_err", {30'b0, f_err, r_err}, 32'd3);
    step();
    d_req = 1; d_we = 0; d_addr = 32'h88;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("to_no_gnt", {29'b0, f_d_gnt, f_mem_req, r_d_gnt}, 32'd0);
      chk("to_err_sticky", {31'b0, f_err}, 32'd1);
      step();
    end
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    settle();
    chk("to_late_rvalid", {28'b0, f_i_rvalid, f_d_rvalid, r_i_rvalid, r_d_rvalid}, 32'd0);
    step();
    idle_inputs();

    // Reset during WAIT drops the in-flight response.
    do_reset();
    settle();
    chk("rst_clears_err", {30'b0, f_err, r_err}, 32'd0);
    step();
    i_req = 1; i_addr = 32'h60;
    settle();
    chk("rw_gnt", {31'b0, f_i_gnt}, 32'd1);
    step();
    i_req = 0;
    RSTN = 0;
    settle();
    chk("rw_in_reset", {30'b0, f_i_rvalid, f_mem_req}, 32'd0);
    step();
    RSTN = 1;
    mem_rvalid = 1; mem_rdata = 32'hBBBB_0001;
    settle();
    chk("rw_dropped", {28'b0, f_i_rvalid, f_d_rvalid, r_i_rvalid, r_d_rvalid}, 32'd0);
    chk("rw_err", {31'b0, f_err}, 32'd0);
    step();
    mem_rvalid = 0;
    i_req = 1; i_addr = 32'h64;
    settle();
    chk("rw_regrant", {30'b0, f_i_gnt, r_i_gnt}, 32'd3);
    chk("rw_regrant_addr", f_mem_addr, 32'h64);
    step();
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared single-port memory between the CPU's instruction-fetch requester (I) and load/store requester (D).
- Removes the separate instruction array: fetch stage and execute stage both issue requests here and stall until their response.
- One outstanding memory transaction at a time. Selectable arbitration policy. Watchdog timeout with a sticky error flag.

Parameters:
- ADDR_W, 32, byte-address width of requester and memory address buses.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RR_EN, 0, 0 = fixed priority (D over I); 1 = round-robin between I and D.
- TIMEOUT, 255, cycles in WAIT without mem_rvalid before a timeout error; must be ≥1 and fit TO_W bits.
- TO_W, 8, width of the timeout counter.

Ports:
- CLK  in  1  clock, all state updates on posedge
- RSTN  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held high until i_gnt
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  fetch request accepted
- i_rvalid  out  1  fetch response pulse
- i_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  data response pulse (load data or store ack)
- d_rdata  out  DATA_W  load data; 0 on store ack
- mem_req  out  1  memory command pulse
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory byte address (passed unchanged)
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables; all-ones for fetch and load
- mem_rvalid  in  1  memory completion; at least 1 cycle after mem_req
- mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid
- err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, WAIT. Registered state: owner (0 = I, 1 = D), last_owner, timeout counter, err. Reset values: state = IDLE, owner = 0, last_owner = 0, counter = 0, err = 0.
- During reset, all outputs are 0: gnt, rvalid, mem_req, mem_we and all data and address buses.
- IDLE with any request, err = 0:
  - The winner's gnt and mem_req are asserted combinationally in the same cycle.
  - mem_we, mem_addr, mem_wdata and mem_be are driven from the winner.
  - Next cycle: state = WAIT, owner = winner, last_owner = winner, counter = 0.
- IDLE with no request: all command outputs are 0 and mem_* buses are 0.
- Arbitration, both requesting, RR_EN = 0: D wins.
- Arbitration, both requesting, RR_EN = 1: the requester that is not last_owner wins. First contention after reset therefore grants D.
- Arbitration, single requester: that requester wins under either policy.
- A loser is not granted; its req must stay high. gnt is never asserted in WAIT.
- WAIT, mem_rvalid = 1:
  - The owner's rvalid pulses for 1 cycle in that same cycle (combinational).
  - rdata = mem_rdata for a fetch or load; d_rdata = 0 for a store.
  - Next state = IDLE.
  - The non-owner's rvalid and rdata are 0 at all times.
- WAIT, mem_rvalid = 0: counter increments. When counter == TIMEOUT-1 and mem_rvalid = 0:
  - The owner's rvalid pulses with rdata = 0.
  - err is set (sticky until reset). State = IDLE.
- err = 1: no further grants; all requests are ignored; mem_rvalid is ignored.
- mem_rvalid in IDLE is ignored.
- Minimum transaction spacing is 2 cycles: grant at cycle t, earliest response at t+1, earliest next grant at t+2.
- A new request asserted in the response cycle is granted at the earliest in the following cycle.
- Reset asserted mid-WAIT: return immediately to IDLE. The in-flight response is dropped; no rvalid is produced. Requesters must also be reset.
- No address decode, alignment check or data reordering is performed.

Test Plan:
- Fetch only: i_req = 1, i_addr = 0x10; memory responds 3 cycles after mem_req with 0x0340_00EF -> i_gnt and mem_req asserted at t0 with mem_addr = 0x10 and mem_be = 0xF; i_rvalid and i_rdata = 0x0340_00EF at t3; d_rvalid stays 0.
- Store: d_req = 1, d_we = 1, d_addr = 0x1FC, d_wdata = 0xDEAD_BEEF, d_be = 0x3 -> mem_we = 1, mem_wdata = 0xDEAD_BEEF, mem_be = 0x3; d_rvalid asserted with d_rdata = 0 on mem_rvalid.
- Contention, RR_EN = 0, both requesting continuously, memory latency 1 -> grant sequence D, D, D, … with one grant every 2 cycles; i_gnt never asserted.
- Contention, RR_EN = 1, same stimulus -> grant sequence D, I, D, I; each response routed to the correct requester with the correct rdata.
- Timeout: TIMEOUT = 4, memory never responds to a fetch -> i_rvalid asserted with i_rdata = 0 and err = 1 in the 4th WAIT cycle. A subsequent d_req is never granted, and a later mem_rvalid is ignored.
- Reset in WAIT: assert RSTN = 0 one cycle after the grant, release, then pulse mem_rvalid -> no rvalid output, state IDLE, err = 0, and the next i_req is granted normally.
